// File: rtl/glyph_serializer_pkg.sv
// Shared types and defaults for the glyph serializer slice: FSM states, default geometry, glyph bitmap table.
// The table holds 4 glyphs x 16 rows of 8-pixel words; anything outside it reads as blank.
package glyph_pkg;

  localparam int GLYPH_W_DEFAULT    = 8;
  localparam int GLYPH_H_DEFAULT    = 16;
  localparam int NUM_GLYPHS_DEFAULT = 4;

  localparam int ROM_W = 8;
  localparam int ROM_H = 16;
  localparam int ROM_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [ROM_W-1:0] GLYPH_ROM [0:ROM_N*ROM_H-1] = '{
    8'h0C, 8'h1C, 8'h7C, 8'hEC, 8'h0C, 8'h0C, 8'h0C, 8'h0C,
    8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C,
    8'h3C, 8'hFE, 8'hC3, 8'h03, 8'h03, 8'h03, 8'h06, 8'h0C,
    8'h18, 8'h30, 8'h60, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF,
    8'h3C, 8'h7E, 8'hE7, 8'hE3, 8'h03, 8'h03, 8'h07, 8'h7E,
    8'h7E, 8'h07, 8'h03, 8'h03, 8'hE3, 8'hE7, 8'h7E, 8'h3C,
    8'h1E, 8'h3E, 8'h66, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hFF,
    8'hFF, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06
  };

  function automatic logic [ROM_W-1:0] glyph_word(input int code, input int row);
    logic [5:0] idx;
    if (code < 0 || code >= ROM_N || row < 0 || row >= ROM_H) return '0;
    idx = 6'(code * ROM_H + row);
    return GLYPH_ROM[idx];
  endfunction

endpackage

// File: rtl/glyph_serializer_if.sv
// Request and pixel-stream handshake bundle: address generator drives requests, pixel mux drives pixReady.
// The serializer sits on the slave modport.
interface glyph_serializer_if
  import glyph_pkg::*;
#(
  parameter int CODE_W = (NUM_GLYPHS_DEFAULT > 1) ? $clog2(NUM_GLYPHS_DEFAULT) : 1,
  parameter int ROW_W  = $clog2(GLYPH_H_DEFAULT)
);
  logic              reqValid;
  logic              reqReady;
  logic [CODE_W-1:0] reqCode;
  logic [ROW_W-1:0]  reqRow;
  logic              reqInvert;
  logic              pixValid;
  logic              pixReady;
  logic              pixData;
  logic              pixLast;

  modport master (
    output reqValid, reqCode, reqRow, reqInvert, pixReady,
    input  reqReady, pixValid, pixData, pixLast
  );

  modport slave (
    input  reqValid, reqCode, reqRow, reqInvert, pixReady,
    output reqReady, pixValid, pixData, pixLast
  );
endinterface

// File: rtl/glyph_rom_sync.sv
// Registered-output glyph ROM: word for (code,row) appears one cycle after the address.
// Unpopulated codes and rows beyond the glyph height read as all zeros.
module glyph_rom_sync
  import glyph_pkg::*;
#(
  parameter int GLYPH_W    = GLYPH_W_DEFAULT,
  parameter int GLYPH_H    = GLYPH_H_DEFAULT,
  parameter int NUM_GLYPHS = NUM_GLYPHS_DEFAULT,
  parameter int CODE_W     = 2,
  parameter int ROW_W      = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [CODE_W-1:0]  code,
  input  logic [ROW_W-1:0]   row,
  output logic [GLYPH_W-1:0] word
);
  // Table words are MSB-aligned into the configured row width.
  localparam int NB = (GLYPH_W < ROM_W) ? GLYPH_W : ROM_W;

  logic [ROM_W-1:0]   tab;
  logic [GLYPH_W-1:0] word_d;

  always_comb begin
    tab = '0;
    if (int'(code) < NUM_GLYPHS && int'(row) < GLYPH_H) tab = glyph_word(int'(code), int'(row));
    word_d = '0;
    for (int i = 0; i < NB; i++) word_d[GLYPH_W-1-i] = tab[ROM_W-1-i];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) word <= '0;
    else         word <= word_d;
  end
endmodule

// File: rtl/glyph_serializer.sv
// Glyph row -> MSB-first serial pixel stream; GLYPH_DOUBLE_EN holds each pixel for two beats.
// Latency 2 cycles accept->first pixel; pixValid/pixData/pixLast hold under pixReady backpressure.
module glyph_serializer
  import glyph_pkg::*;
#(
  parameter int GLYPH_W    = GLYPH_W_DEFAULT,
  parameter int GLYPH_H    = GLYPH_H_DEFAULT,
  parameter int NUM_GLYPHS = NUM_GLYPHS_DEFAULT,
  parameter int CODE_W     = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1,
  parameter int ROW_W      = $clog2(GLYPH_H)
) (
  input  logic               clk,
  input  logic               resetN,
  glyph_serializer_if.slave  bus,
  output logic               busy
);
`ifdef GLYPH_DOUBLE_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif
  localparam int CNT_W = ((GLYPH_W > 1) ? $clog2(GLYPH_W) : 1) + DBL;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((GLYPH_W << DBL) - 1);

  state_t             state;
  logic [CODE_W-1:0]  code_q;
  logic [ROW_W-1:0]   row_q;
  logic               inv_q;
  logic [GLYPH_W-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic [GLYPH_W-1:0] rom_word;
  logic               req_hs;
  logic               beat;
  logic               shift_now;
  logic [CODE_W-1:0]  rom_code;
  logic [ROW_W-1:0]   rom_row;

  assign bus.pixValid = (state == SHIFT);
  assign bus.pixLast  = (state == SHIFT) && (cnt == LAST_BEAT);
  assign bus.pixData  = (state == SHIFT) && (shreg[GLYPH_W-1] ^ inv_q);
  assign bus.reqReady = resetN && ((state == IDLE) || (bus.pixReady && bus.pixLast));
  assign busy         = (state != IDLE);
  assign req_hs       = bus.reqValid && bus.reqReady;
  assign beat         = bus.pixValid && bus.pixReady;
  assign shift_now    = (DBL == 0) || cnt[0];

  // The ROM is addressed straight from the request on the accept edge so the
  // word is ready one cycle later; afterwards the request register keeps it stable.
  assign rom_code = req_hs ? bus.reqCode : code_q;
  assign rom_row  = req_hs ? bus.reqRow  : row_q;

  glyph_rom_sync #(
    .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .NUM_GLYPHS(NUM_GLYPHS),
    .CODE_W(CODE_W), .ROW_W(ROW_W)
  ) u_rom (
    .clk(clk), .resetN(resetN), .code(rom_code), .row(rom_row), .word(rom_word)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      code_q <= '0;
      row_q  <= '0;
      inv_q  <= 1'b0;
      shreg  <= '0;
      cnt    <= '0;
    end else begin
      if (req_hs) begin
        code_q <= bus.reqCode;
        row_q  <= bus.reqRow;
        inv_q  <= bus.reqInvert;
      end
      case (state)
        IDLE: if (req_hs) state <= FETCH;
        FETCH: begin
          shreg <= rom_word;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: if (beat) begin
          if (bus.pixLast) begin
            state <= req_hs ? FETCH : IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (shift_now) shreg <= shreg << 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
